// File: rtl/gpr_pkg.sv
// Shared constants for the multi-port general-purpose register file.
package gpr_pkg;
  localparam int GPR_WIDTH_DEF  = 32;
  localparam int GPR_DEPTH_DEF  = 32;
  localparam int GPR_NUM_RD_DEF = 2;
  localparam int ZERO_REG       = 0;
endpackage

// File: rtl/gpr_rd_port.sv
// One registered read port: mux, zero-index force, optional same-edge write
// forwarding (GPR_BYPASS_EN) and the rd_data/rd_busy output flops.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int WIDTH = GPR_WIDTH_DEF,
  parameter int DEPTH = GPR_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AW-1:0]          rd_addr_i,
  input  logic [DEPTH*WIDTH-1:0] regs_flat_i,
  input  logic [DEPTH-1:0]       pend_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pend_set_i,
  input  logic [AW-1:0]          pend_addr_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   rd_busy_o
);

  logic [WIDTH-1:0] rd_data_d, rd_data_q;
  logic             rd_busy_d, rd_busy_q;
  logic             addr_is_zero;

  assign addr_is_zero = (rd_addr_i == AW'(ZERO_REG));

`ifdef GPR_BYPASS_EN
  logic wr_hit, set_hit;
  assign wr_hit  = wr_en_i && (wr_addr_i == rd_addr_i);
  assign set_hit = pend_set_i && (pend_addr_i == rd_addr_i);
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i, pend_set_i, pend_addr_i};
`endif

  always_comb begin
    rd_data_d = regs_flat_i[rd_addr_i*WIDTH +: WIDTH];
    rd_busy_d = pend_i[rd_addr_i];
`ifdef GPR_BYPASS_EN
    // A retiring write clears busy unless a new producer claims the register this edge.
    if (wr_hit) begin
      rd_data_d = wr_data_i;
      if (!set_hit) rd_busy_d = 1'b0;
    end
`endif
    if (addr_is_zero) begin
      rd_data_d = '0;
      rd_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_busy_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port register file with r0 hardwired to zero and a pending-write
// scoreboard for RAW detection. Optional macro: GPR_BYPASS_EN (write forwarding).
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int WIDTH  = GPR_WIDTH_DEF,
  parameter int DEPTH  = GPR_DEPTH_DEF,
  parameter int NUM_RD = GPR_NUM_RD_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    pend_set,
  input  logic [AW-1:0]           pend_addr
);

  logic [WIDTH-1:0]       regs_q [DEPTH];
  logic [DEPTH*WIDTH-1:0] regs_flat;
  logic [DEPTH-1:0]       pend_d, pend_q;
  logic                   wr_ok, set_ok;

  assign wr_ok  = wr_en && (wr_addr != AW'(ZERO_REG));
  assign set_ok = pend_set && (pend_addr != AW'(ZERO_REG));

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
  end

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[wr_addr]   = 1'b0;
    if (set_ok) pend_d[pend_addr] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    gpr_rd_port #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AW   (AW)
    ) u_rd_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr_i  (rd_addr[p*AW +: AW]),
      .regs_flat_i(regs_flat),
      .pend_i     (pend_q),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .pend_set_i (pend_set),
      .pend_addr_i(pend_addr),
      .rd_data_o  (rd_data[p*WIDTH +: WIDTH]),
      .rd_busy_o  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed self-checking bench for gpr_file_mp (default 32x32, two read ports).
module tb_gpr_file_mp;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                    clk;
  logic                    rst_n;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic                    pend_set;
  logic [AW-1:0]           pend_addr;

  int checks = 0;
  int errors = 0;

  gpr_file_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .pend_set (pend_set),
    .pend_addr(pend_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    pend_set = 0; pend_addr = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    idle_inputs();
    set_rd(0, 0);
    rst_n = 0;
    #12;
    checks++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      errors++;
      $display("FAIL reset_out: rd_data=%h rd_busy=%b required 0/0", rd_data, rd_busy);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(AW'(i), AW'(DEPTH-1-i));
      step();
      checks++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        errors++;
        $display("FAIL reset_read[%0d]: rd_data=%h rd_busy=%b required 0/0", i, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    set_rd(5, 0);
    step();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL write_r5: got %h busy %b required deadbeef busy 00", rd_data[31:0], rd_busy);
    end
    wr_en = 1; wr_addr = 31; wr_data = 32'h0BADF00D;
    step();
    idle_inputs();
    set_rd(0, 31);
    step();
    checks++;
    if (rd_data[63:32] !== 32'h0BADF00D || rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL write_r31: got %h required 0badf00d_00000000", rd_data);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    pend_set = 1; pend_addr = 0;
    step();
    idle_inputs();
    set_rd(0, 0);
    step();
    checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL zero_reg: rd_data=%h rd_busy=%b required 0/00", rd_data, rd_busy);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 7; wr_data = 32'h11111111;
    step();
    wr_en = 1; wr_addr = 7; wr_data = 32'h12345678;
    set_rd(0, 7);
    step();
    idle_inputs();
    checks++;
`ifdef GPR_BYPASS_EN
    if (rd_data[63:32] !== 32'h12345678) begin
      errors++;
      $display("FAIL same_edge_r7: got %h required 12345678", rd_data[63:32]);
    end
`else
    if (rd_data[63:32] !== 32'h11111111) begin
      errors++;
      $display("FAIL same_edge_r7: got %h required 11111111", rd_data[63:32]);
    end
`endif
    step();
    checks++;
    if (rd_data[63:32] !== 32'h12345678) begin
      errors++;
      $display("FAIL next_edge_r7: got %h required 12345678", rd_data[63:32]);
    end
  endtask

  task automatic test_pending();
    logic exp_b;
    pend_set = 1; pend_addr = 9;
    set_rd(9, 8);
    step();
    idle_inputs();
    step();
    checks++;
    if (rd_busy !== 2'b01) begin
      errors++;
      $display("FAIL pend_r9: rd_busy=%b required 01", rd_busy);
    end
    wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    pend_set = 1; pend_addr = 9;
    step();
    idle_inputs();
    step();
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL pend_set_wins: busy=%b data=%h required 1/99", rd_busy[0], rd_data[31:0]);
    end
    wr_en = 1; wr_addr = 9; wr_data = 32'h9A;
    step();
    idle_inputs();
`ifdef GPR_BYPASS_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    checks++;
    if (rd_busy[0] !== exp_b) begin
      errors++;
      $display("FAIL pend_retire_edge: busy=%b required %b", rd_busy[0], exp_b);
    end
    step();
    checks++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h9A) begin
      errors++;
      $display("FAIL pend_cleared: busy=%b data=%h required 00/9a", rd_busy, rd_data[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1; wr_addr = AW'(i + 10); wr_data = 32'hC0DE0000 + i;
      set_rd(AW'(i + 9), AW'(i + 9));
      step();
      if (i > 1) begin
        checks++;
        if (rd_data[31:0] !== 32'hC0DE0000 + i - 1 || rd_data[63:32] !== 32'hC0DE0000 + i - 1) begin
          errors++;
          $display("FAIL b2b[%0d]: got %h required both %h", i, rd_data, 32'hC0DE0000 + i - 1);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5;
    pend_set = 1; pend_addr = 3;
    set_rd(3, 3);
    step();
    idle_inputs();
    step();
    checks++;
    if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_busy !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_r3: data=%h busy=%b required a5a5a5a5/11", rd_data[31:0], rd_busy);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL async_clear: data=%h busy=%b required 0/00", rd_data, rd_busy);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_r3: data=%h busy=%b required 0/00", rd_data, rd_busy);
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    set_rd(0, 0);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
